// File: rtl/stereo_sched_pkg.sv
// rtl/stereo_sched_pkg.sv - shared types and defaults for the stereo source scheduler
package stereo_sched_pkg;

  // Scheduler FSM states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam int unsigned default_width_lp     = 24;
  localparam int unsigned default_min_dwell_lp = 4;
  localparam int unsigned default_cnt_width_lp = 16;

  // One stereo frame at the default sample width; the top re-declares it at width_p
  typedef struct packed {
    logic [default_width_lp-1:0] right;
    logic [default_width_lp-1:0] left;
  } frame_t;

endpackage

// File: rtl/stereo_pipe_reg.sv
// rtl/stereo_pipe_reg.sv - one-entry elastic output register for stereo frames
module stereo_pipe_reg
  import stereo_sched_pkg::*;
#(
  parameter type data_t = frame_t
) (
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  load_i,
  input  data_t data_i,
  input  logic  consume_i,
  output logic  valid_o,
  output data_t data_o
);

  // Load wins over consume so a same-cycle load/unload keeps the entry full
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (consume_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/stereo_src_sched.sv
// rtl/stereo_src_sched.sv - frame-boundary source switch with dwell, drain and mute (option: DRAIN_UNSEL_EN)
module stereo_src_sched
  import stereo_sched_pkg::*;
#(
  parameter int unsigned width_p     = default_width_lp,
  parameter int unsigned min_dwell_p = default_min_dwell_lp,
  parameter int unsigned cnt_width_p = default_cnt_width_lp
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     src0_right_i,
  input  logic [width_p-1:0]     src0_left_i,
  input  logic                   src0_valid_i,
  output logic                   src0_ready_o,
  input  logic [width_p-1:0]     src1_right_i,
  input  logic [width_p-1:0]     src1_left_i,
  input  logic                   src1_valid_i,
  output logic                   src1_ready_o,
  input  logic                   sel_i,
  input  logic                   mute_i,
  output logic [width_p-1:0]     right_o,
  output logic [width_p-1:0]     left_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   sel_o,
  output logic                   switching_o,
  output logic [cnt_width_p-1:0] frames_o
);

  typedef struct packed {
    logic [width_p-1:0] right;
    logic [width_p-1:0] left;
  } frame_w_t;

  state_e   state;
  logic     run;
  logic     out_free;
  logic     grant_ready;
  logic     unsel_ready;
  logic     grant_valid;
  logic     accept;
  logic     frames_sat;
  logic     dwell_met;
  frame_w_t grant_frame;
  frame_w_t load_frame;
  frame_w_t out_frame;

  // Readies depend only on state, the output register and ready_i
  assign run         = (state == ST_RUN);
  assign out_free    = ~valid_o | ready_i;
  assign grant_ready = run & out_free;

`ifdef DRAIN_UNSEL_EN
  // Idle source keeps flowing and its frames are dropped; still stalled during DRAIN
  assign unsel_ready = run;
`else
  assign unsel_ready = 1'b0;
`endif

  assign src0_ready_o = sel_o ? unsel_ready : grant_ready;
  assign src1_ready_o = sel_o ? grant_ready : unsel_ready;

  assign grant_valid = sel_o ? src1_valid_i : src0_valid_i;
  assign accept      = grant_valid & grant_ready;

  assign grant_frame = sel_o ? frame_w_t'{right: src1_right_i, left: src1_left_i}
                             : frame_w_t'{right: src0_right_i, left: src0_left_i};
  // Mute zeros the payload only; the handshake is untouched
  assign load_frame  = mute_i ? '0 : grant_frame;

  stereo_pipe_reg #(
    .data_t (frame_w_t)
  ) u_pipe_reg (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (accept),
    .data_i    (load_frame),
    .consume_i (ready_i),
    .valid_o   (valid_o),
    .data_o    (out_frame)
  );

  assign right_o = out_frame.right;
  assign left_o  = out_frame.left;

  assign frames_sat = &frames_o;
  assign dwell_met  = frames_o >= cnt_width_p'(min_dwell_p);

  // Scheduler FSM: dwell counting in RUN, drain-then-swap in DRAIN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_RUN;
      sel_o       <= 1'b0;
      frames_o    <= '0;
      switching_o <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept && !frames_sat) begin
            frames_o <= frames_o + cnt_width_p'(1);
          end
          if ((sel_i != sel_o) && dwell_met) begin
            state       <= ST_DRAIN;
            switching_o <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Request withdrawn: resume the current source with its count intact
          if (sel_i == sel_o) begin
            state       <= ST_RUN;
            switching_o <= 1'b0;
          end else if (out_free) begin
            state       <= ST_RUN;
            switching_o <= 1'b0;
            sel_o       <= ~sel_o;
            frames_o    <= '0;
          end
        end
        default: begin
          state       <= ST_RUN;
          switching_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_src_sched.sv
// tb/tb_stereo_src_sched.sv - scoreboard bench for stereo_src_sched
module tb_stereo_src_sched;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [W-1:0]  src0_right_i, src0_left_i, src1_right_i, src1_left_i;
  logic          src0_valid_i, src1_valid_i;
  logic          src0_ready_o, src1_ready_o;
  logic          sel_i, mute_i, ready_i;
  logic [W-1:0]  right_o, left_o;
  logic          valid_o, sel_o, switching_o;
  logic [15:0]   frames_o;

  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;
  logic unsel_exp;

  stereo_src_sched dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .src0_right_i (src0_right_i),
    .src0_left_i  (src0_left_i),
    .src0_valid_i (src0_valid_i),
    .src0_ready_o (src0_ready_o),
    .src1_right_i (src1_right_i),
    .src1_left_i  (src1_left_i),
    .src1_valid_i (src1_valid_i),
    .src1_ready_o (src1_ready_o),
    .sel_i        (sel_i),
    .mute_i       (mute_i),
    .right_o      (right_o),
    .left_o       (left_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .sel_o        (sel_o),
    .switching_o  (switching_o),
    .frames_o     (frames_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one frame on a source and hold it until the DUT takes it
  task automatic send(input bit s, input logic [W-1:0] r, input logic [W-1:0] l);
    int waited;
    bit done;
    logic rdy;
    waited = 0;
    done   = 1'b0;
    if (s) begin
      src1_valid_i = 1'b1; src1_right_i = r; src1_left_i = l;
    end else begin
      src0_valid_i = 1'b1; src0_right_i = r; src0_left_i = l;
    end
    #1;
    while (!done) begin
      rdy = s ? src1_ready_o : src0_ready_o;
      if (rdy === 1'b1) begin
        sb.push_back(mute_i ? '0 : {r, l});
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 20) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: src%0d ready stayed 0, expected 1 within 20 cycles", s);
          done = 1'b1;
        end else begin
          @(posedge clk);
          #2;
        end
      end
    end
  endtask

  task automatic idle(input bit s);
    if (s) src1_valid_i = 1'b0;
    else   src0_valid_i = 1'b0;
  endtask

  // Output monitor: every output handshake must match the oldest expected frame
  always @(negedge clk) begin
    if (!reset_i && valid_o && ready_i) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got frame R=0x%0h L=0x%0h, expected none", right_o, left_o);
      end else begin
        mon_exp = sb.pop_front();
        if ({right_o, left_o} !== mon_exp) begin
          n_fail++;
          $display("FAIL out_frame: got R=0x%0h L=0x%0h, expected R=0x%0h L=0x%0h",
                   right_o, left_o, mon_exp[2*W-1:W], mon_exp[W-1:0]);
        end
      end
    end
  end

  initial begin
`ifdef DRAIN_UNSEL_EN
    unsel_exp = 1'b1;
`else
    unsel_exp = 1'b0;
`endif
    reset_i = 1'b1;
    src0_right_i = '0; src0_left_i = '0; src0_valid_i = 1'b0;
    src1_right_i = '0; src1_left_i = '0; src1_valid_i = 1'b0;
    sel_i = 1'b0; mute_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_frames", frames_o, 0);
    chk("rst_switching", switching_o, 0);
    chk("rst_src0_ready", src0_ready_o, 1);
    chk("rst_src1_ready", src1_ready_o, unsel_exp);

    // Stream from src0, switch requested after two frames
    ready_i = 1'b1;
    step();
    send(0, 24'h000001, 24'h000002);
    chk("lat_valid", valid_o, 1);
    chk("frames_1", frames_o, 1);
    send(0, 24'h000003, 24'h000004);
    chk("frames_2", frames_o, 2);
    sel_i = 1'b1;
    send(0, 24'h000005, 24'h000006);
    chk("frames_3", frames_o, 3);
    chk("dwell_sw3", switching_o, 0);
    send(0, 24'h000007, 24'h000008);
    chk("frames_4", frames_o, 4);
    chk("dwell_sw4", switching_o, 0);
    send(0, 24'h000009, 24'h00000A);
    chk("drain_sw", switching_o, 1);
    chk("drain_frames", frames_o, 5);
    chk("drain_sel", sel_o, 0);
    chk("drain_rdy0", src0_ready_o, 0);
    chk("drain_rdy1", src1_ready_o, 0);
    idle(0);
    step();
    chk("swap_sw", switching_o, 0);
    chk("swap_sel", sel_o, 1);
    chk("swap_frames", frames_o, 0);

    // src1 stream, then switch back while the output is stalled
    send(1, 24'h0000A1, 24'h0000A2);
    send(1, 24'h0000A3, 24'h0000A4);
    send(1, 24'h0000A5, 24'h0000A6);
    send(1, 24'h0000A7, 24'h0000A8);
    chk("s1_frames_4", frames_o, 4);
    ready_i = 1'b0;
    sel_i   = 1'b0;
    idle(1);
    step();
    chk("stall_sw", switching_o, 1);
    chk("stall_valid", valid_o, 1);
    chk("stall_right", right_o, 24'h0000A7);
    chk("stall_left", left_o, 24'h0000A8);
    step();
    chk("stall_sw2", switching_o, 1);
    chk("stall_sel", sel_o, 1);
    chk("stall_right2", right_o, 24'h0000A7);
    ready_i = 1'b1;
    #1;
    chk("drain_rdy1_hold", src1_ready_o, 0);
    step();
    chk("unstall_sel", sel_o, 0);
    chk("unstall_frames", frames_o, 0);
    chk("unstall_sw", switching_o, 0);
    chk("unstall_valid", valid_o, 0);

    // Switch request withdrawn during DRAIN
    send(0, 24'h000010, 24'h000011);
    send(0, 24'h000012, 24'h000013);
    send(0, 24'h000014, 24'h000015);
    send(0, 24'h000016, 24'h000017);
    sel_i = 1'b1;
    idle(0);
    step();
    chk("cancel_sw_in", switching_o, 1);
    sel_i = 1'b0;
    step();
    chk("cancel_sw_out", switching_o, 0);
    chk("cancel_sel", sel_o, 0);
    chk("cancel_frames", frames_o, 4);

    // Mute, with src1 pushing while ungranted
    src1_valid_i = 1'b1; src1_right_i = 24'h0BAD01; src1_left_i = 24'h0BAD02;
    #1;
    chk("unsel_rdy1", src1_ready_o, unsel_exp);
    mute_i = 1'b1;
    send(0, 24'h7FFFFF, 24'h7FFFFF);
    chk("mute_frames", frames_o, 5);
    chk("mute_valid", valid_o, 1);
    mute_i = 1'b0;
    send(0, 24'h654321, 24'h00ABCD);
    chk("unmute_frames", frames_o, 6);
    idle(0);
    idle(1);

    // Move to src1, then reset with a frame held in the register
    sel_i = 1'b1;
    step();
    step();
    chk("pre_rst_sel", sel_o, 1);
    src0_valid_i = 1'b1; src0_right_i = 24'h0BAD03; src0_left_i = 24'h0BAD04;
    #1;
    chk("unsel_rdy0", src0_ready_o, unsel_exp);
    ready_i = 1'b0;
    send(1, 24'h0000C1, 24'h0000C2);
    idle(1);
    idle(0);
    chk("pre_rst_valid", valid_o, 1);
    #2;
    reset_i = 1'b1;
    sb.delete();
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_sel", sel_o, 0);
    chk("arst_frames", frames_o, 0);
    chk("arst_right", right_o, 0);
    chk("arst_src0_ready", src0_ready_o, 1);
    step();
    sel_i   = 1'b0;
    reset_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) step();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
